// File: rtl/display_pkg.sv
// Shared types and defaults for the four-digit seven-segment scan multiplexer.
package display_pkg;

    localparam int DIGITS            = 4;
    localparam int SCAN_DIV_DEFAULT  = 100000;
    localparam int BLINK_DIV_DEFAULT = 25000000;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] sel_t;

    function automatic sel_t next_sel(input sel_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/display_scan_mux_tick_divider.sv
// Free-running modulo-N counter; wrap is high during the cycle the count sits at N-1.
module tick_divider #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    output logic wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wrap = (cnt == LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit scan multiplexer with per-frame input snapshot and digit blinking.
// Optional leading-zero blanking of the leftmost digit: DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] blink_mask,
    input  logic       dp_in,
    input  logic       display_on,
    output logic [3:0] x,
    output logic [1:0] sw,
    output logic       dec,
    output logic       enable
);

    logic   scan_wrap;
    logic   blink_wrap;
    logic   frame_end;
    logic   lzb_blank;

    sel_t   sel;
    digit_t snap [DIGITS];
    logic [DIGITS-1:0] mask_snap;
    logic   dp_snap;
    logic   on_snap;
    logic   valid;
    logic   blink_phase;

    tick_divider #(.N(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .wrap (scan_wrap)
    );

    tick_divider #(.N(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .wrap (blink_wrap)
    );

    // Last cycle of the leftmost digit's dwell closes the frame.
    assign frame_end = scan_wrap && (sel == sel_t'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= '0;
            valid       <= 1'b0;
            blink_phase <= 1'b0;
            mask_snap   <= '0;
            dp_snap     <= 1'b0;
            on_snap     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (scan_wrap) begin
                sel <= next_sel(sel);
            end
            if (frame_end) begin
                snap[0]   <= d0;
                snap[1]   <= d1;
                snap[2]   <= d2;
                snap[3]   <= d3;
                mask_snap <= blink_mask;
                dp_snap   <= dp_in;
                on_snap   <= display_on;
                valid     <= 1'b1;
            end
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    assign lzb_blank = (sel == sel_t'(DIGITS - 1)) && (snap[DIGITS-1] == '0);
`else
    assign lzb_blank = 1'b0;
`endif

    // Outputs depend on registered state only.
    always_comb begin
        x      = snap[sel];
        sw     = sel;
        dec    = ~dp_snap;
        enable = valid & on_snap & ~(mask_snap[sel] & blink_phase) & ~lzb_blank;
    end

endmodule
